hazard_stall_unit: RTL

- Parametrised load-use and branch hazard detection unit for the 5-stage pipeline. It sits between the IF/ID register and the ID/EX control mux.
- Adds a multi-cycle stall counter FSM for memories with LOAD_LAT > 1, and stall on branches resolved in ID.
- Adds an IF/ID flush for taken branches and optional register-0 exclusion.
- Outputs keep the existing polarity convention: MuxSig/IFIDWrite/PCWrite = 1 means run, 0 means stall/bubble.

---
 rtl/hazard_stall_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// +-----------------------------------------------------------------------------
// | hazard_stall_unit : load-use / branch hazard detection with a multi-cycle
// | stall counter and IF/ID flush on taken branches.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module hazard_stall_unit #(
   parameter int REG_AW    = 5,
   parameter int LOAD_LAT  = 1,
   parameter int ZERO_SKIP = 1,
   parameter int CNT_W     = 3
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              IDEXMemRead,
   input  logic              IDEXRegWrite,
   input  logic [REG_AW-1:0] IDEXrd,
   input  logic              EXMEMMemRead,
   input  logic [REG_AW-1:0] EXMEMrd,
   input  logic [REG_AW-1:0] IFIDrs,
   input  logic [REG_AW-1:0] IFIDrt,
   input  logic              IFIDUsesRt,
   input  logic              IFIDBranch,
   input  logic              BranchTaken,
   output logic              MuxSig,
   output logic              IFIDWrite,
   output logic              PCWrite,
   output logic              IFIDFlush,
   output logic [CNT_W-1:0]  StallCnt
);

   localparam logic [1:0]       S_IDLE     = 2'd0;
   localparam logic [1:0]       S_STALL    = 2'd1;
   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_LAT      = CNT_W'(LOAD_LAT);
   localparam logic [CNT_W-1:0] C_LAT_P1   = CNT_W'(LOAD_LAT + 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] need_n;
   logic             src_ex, src_mem;
   logic             stall;

   function automatic logic f_match(input logic [REG_AW-1:0] a,
                                    input logic [REG_AW-1:0] d);
      return (a == d) && !((ZERO_SKIP != 0) && (d == '0));
   endfunction

   assign src_ex  = f_match(IFIDrs, IDEXrd)  || (IFIDUsesRt && f_match(IFIDrt, IDEXrd));
   assign src_mem = f_match(IFIDrs, EXMEMrd) || (IFIDUsesRt && f_match(IFIDrt, EXMEMrd));

   // Cases are ordered by ascending stall length, so the last hit is the maximum.
   always_comb begin
      need_n = '0;
      if (IFIDBranch && IDEXRegWrite && !IDEXMemRead && src_ex) need_n = C_ONE;
      if (IFIDBranch && EXMEMMemRead && src_mem)                 need_n = C_ONE;
      if (IDEXMemRead && src_ex)                                 need_n = C_LAT;
      if (IFIDBranch && IDEXMemRead && src_ex)                   need_n = C_LAT_P1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q holds the stall cycles still to go, including the current one.
   always_comb begin
      state_d = S_IDLE;
      cnt_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (need_n > C_ONE) begin
               state_d = S_STALL;
               cnt_d   = need_n - C_ONE;
            end
         end
         S_STALL: begin
            if (cnt_q > C_ONE) begin
               state_d = S_STALL;
               cnt_d   = cnt_q - C_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      stall    = 1'b0;
      StallCnt = '0;
      if (Rst_n) begin
         if (state_q == S_STALL) begin
            stall    = 1'b1;
            StallCnt = cnt_q - C_ONE;
         end else if (need_n != '0) begin
            stall    = 1'b1;
            StallCnt = need_n - C_ONE;
         end
      end
      MuxSig    = !stall;
      IFIDWrite = !stall;
      PCWrite   = !stall;
      IFIDFlush = Rst_n && IFIDBranch && BranchTaken && !stall;
   end

endmodule

`default_nettype wire
